// File: rtl/ball.sv
// rtl/ball.sv - keyboard-steered ball position with wall clamping and last-direction outputs
module ball #(
  parameter int SCREEN_X_CENTER = 320,
  parameter int SCREEN_Y_CENTER = 240,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int BALL_SIZE       = 4,
  parameter int STEP            = 1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] BallS,
  output logic [3:0] last_dirX,
  output logic [3:0] last_dirY
);

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Centre positions allowed for the ball so its edge stays inside the playfield
  localparam logic signed [11:0] X_LO   = 12'(X_MIN + BALL_SIZE);
  localparam logic signed [11:0] X_HI   = 12'(X_MAX - BALL_SIZE);
  localparam logic signed [11:0] Y_LO   = 12'(Y_MIN + BALL_SIZE);
  localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - BALL_SIZE);
  localparam logic signed [11:0] STEP_P = 12'(STEP);
  localparam logic signed [11:0] STEP_N = -12'(STEP);

  logic signed [11:0] mx, my;
  logic signed [11:0] mx_new, my_new;
  logic signed [11:0] x_ext, y_ext;
  logic signed [11:0] xn, yn;
  logic [3:0]         dir_x_new, dir_y_new;

  assign BallS = 10'(BALL_SIZE);
  assign x_ext = $signed({2'b00, BallX});
  assign y_ext = $signed({2'b00, BallY});
  assign xn    = x_ext + mx_new;
  assign yn    = y_ext + my_new;

  // Key decode: mapped keys pick one axis of motion, anything else keeps gliding
  always_comb begin
    mx_new    = mx;
    my_new    = my;
    dir_x_new = last_dirX;
    dir_y_new = last_dirY;
    case (keycode)
      KEY_W: begin my_new = STEP_N; mx_new = '0; dir_y_new = 4'hF; dir_x_new = 4'h0; end
      KEY_S: begin my_new = STEP_P; mx_new = '0; dir_y_new = 4'h1; dir_x_new = 4'h0; end
      KEY_A: begin mx_new = STEP_N; my_new = '0; dir_x_new = 4'hF; dir_y_new = 4'h0; end
      KEY_D: begin mx_new = STEP_P; my_new = '0; dir_x_new = 4'h1; dir_y_new = 4'h0; end
      default: ;
    endcase
  end

  // Position/motion update with clamping at the walls; a clamp stops motion on that axis
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      BallX     <= 10'(SCREEN_X_CENTER);
      BallY     <= 10'(SCREEN_Y_CENTER);
      mx        <= '0;
      my        <= '0;
      last_dirX <= 4'h0;
      last_dirY <= 4'h0;
    end else begin
      last_dirX <= dir_x_new;
      last_dirY <= dir_y_new;

      if (xn > X_HI) begin
        BallX <= X_HI[9:0];
        mx    <= '0;
      end else if (xn < X_LO) begin
        BallX <= X_LO[9:0];
        mx    <= '0;
      end else begin
        BallX <= xn[9:0];
        mx    <= mx_new;
      end

      if (yn > Y_HI) begin
        BallY <= Y_HI[9:0];
        my    <= '0;
      end else if (yn < Y_LO) begin
        BallY <= Y_LO[9:0];
        my    <= '0;
      end else begin
        BallY <= yn[9:0];
        my    <= my_new;
      end
    end
  end

endmodule

// File: tb/tb_ball.sv
// tb/tb_ball.sv - directed self-checking bench for ball
module tb_ball;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, BallS;
  logic [3:0] last_dirX, last_dirY;

  int checks = 0;
  int errors = 0;

  ball dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .BallX(BallX),
    .BallY(BallY),
    .BallS(BallS),
    .last_dirX(last_dirX),
    .last_dirY(last_dirY)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // one frame with the given key; outputs are stable 1 time unit after the edge
  task automatic step(input logic [7:0] k);
    keycode = k;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(8'h00);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(8'h04);
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240 || BallS !== 10'd4 || last_dirX !== 4'h0 || last_dirY !== 4'h0) begin
      errors++;
      $display("FAIL reset_state X=%0d Y=%0d S=%0d dx=%h dy=%h required 320 240 4 0 0", BallX, BallY, BallS, last_dirX, last_dirY);
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'h00);
      checks++;
      if (BallX !== 10'd320 || BallY !== 10'd240 || BallS !== 10'd4 || last_dirX !== 4'h0 || last_dirY !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_reset frame %0d X=%0d Y=%0d S=%0d dx=%h dy=%h required 320 240 4 0 0", i, BallX, BallY, BallS, last_dirX, last_dirY);
      end
    end
  endtask

  task automatic test_left();
    do_reset();
    step(8'h04);
    checks++;
    if (BallX !== 10'd319 || last_dirX !== 4'hF || last_dirY !== 4'h0) begin
      errors++;
      $display("FAIL left_first X=%0d dx=%h dy=%h required 319 F 0", BallX, last_dirX, last_dirY);
    end
    for (int i = 0; i < 4; i++) step(8'h04);
    checks++;
    if (BallX !== 10'd315 || BallY !== 10'd240) begin
      errors++;
      $display("FAIL left_fifth X=%0d Y=%0d required 315 240", BallX, BallY);
    end
  endtask

  task automatic test_glide();
    logic [7:0] keys [3] = '{8'h07, 8'h00, 8'h55};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(keys[i]);
      checks++;
      if (BallX !== 10'(321 + i) || last_dirX !== 4'h1 || last_dirY !== 4'h0) begin
        errors++;
        $display("FAIL glide frame %0d X=%0d dx=%h required %0d 1", i, BallX, last_dirX, 321 + i);
      end
    end
  endtask

  task automatic test_walls();
    int exp;
    int bad;
    // left wall
    do_reset();
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      step(8'h04);
      exp = (320 - k < 4) ? 4 : 320 - k;
      if (BallX !== 10'(exp) || last_dirX !== 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL left_wall bad_frames=%0d final X=%0d dx=%h required X=4 dx=F", bad, BallX, last_dirX);
    end
    // clamp stopped motion: releasing the key leaves the ball at the wall
    step(8'h00);
    checks++;
    if (BallX !== 10'd4 || last_dirX !== 4'hF) begin
      errors++;
      $display("FAIL left_wall_release X=%0d dx=%h required 4 F", BallX, last_dirX);
    end
    // pressing into the wall: no move, dir still updated
    step(8'h04);
    checks++;
    if (BallX !== 10'd4 || last_dirX !== 4'hF || last_dirY !== 4'h0) begin
      errors++;
      $display("FAIL into_wall X=%0d dx=%h dy=%h required 4 F 0", BallX, last_dirX, last_dirY);
    end
    step(8'h1A);
    checks++;
    if (BallX !== 10'd4 || BallY !== 10'd239 || last_dirX !== 4'h0 || last_dirY !== 4'hF) begin
      errors++;
      $display("FAIL wall_then_up X=%0d Y=%0d dx=%h dy=%h required 4 239 0 F", BallX, BallY, last_dirX, last_dirY);
    end
    // top wall
    bad = 0;
    for (int k = 2; k <= 300; k++) begin
      step(8'h1A);
      exp = (240 - k < 4) ? 4 : 240 - k;
      if (BallY !== 10'(exp) || last_dirY !== 4'hF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL top_wall bad_frames=%0d final Y=%0d required 4", bad, BallY);
    end
    // right wall
    do_reset();
    bad = 0;
    for (int k = 1; k <= 400; k++) begin
      step(8'h07);
      exp = (320 + k > 635) ? 635 : 320 + k;
      if (BallX !== 10'(exp) || last_dirX !== 4'h1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL right_wall bad_frames=%0d final X=%0d required 635", bad, BallX);
    end
    // bottom wall
    bad = 0;
    for (int k = 1; k <= 300; k++) begin
      step(8'h16);
      exp = (240 + k > 475) ? 475 : 240 + k;
      if (BallY !== 10'(exp) || last_dirY !== 4'h1 || last_dirX !== 4'h0 || BallX !== 10'd635) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bottom_wall bad_frames=%0d final Y=%0d X=%0d required 475 635", bad, BallY, BallX);
    end
  endtask

  task automatic test_vertical();
    logic [7:0] keys  [3] = '{8'h1A, 8'h1A, 8'h16};
    logic [9:0] exp_y [3] = '{10'd239, 10'd238, 10'd239};
    logic [3:0] exp_d [3] = '{4'hF, 4'hF, 4'h1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(keys[i]);
      checks++;
      if (BallY !== exp_y[i] || last_dirY !== exp_d[i] || last_dirX !== 4'h0 || BallX !== 10'd320) begin
        errors++;
        $display("FAIL vertical frame %0d Y=%0d dy=%h dx=%h required %0d %h 0", i, BallY, last_dirY, last_dirX, exp_y[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(8'h04);
    step(8'h04);
    step(8'h07);
    checks++;
    if (BallX !== 10'd319 || last_dirX !== 4'h1) begin
      errors++;
      $display("FAIL reversal X=%0d dx=%h required 319 1", BallX, last_dirX);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(8'h07);
    checks++;
    if (BallX !== 10'd330) begin
      errors++;
      $display("FAIL pre_reset X=%0d required 330", BallX);
    end
    Reset = 1'b1;
    step(8'h07);
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240 || last_dirX !== 4'h0 || last_dirY !== 4'h0 || BallS !== 10'd4) begin
      errors++;
      $display("FAIL mid_reset X=%0d Y=%0d dx=%h dy=%h S=%0d required 320 240 0 0 4", BallX, BallY, last_dirX, last_dirY, BallS);
    end
    Reset = 1'b0;
    step(8'h00);
    checks++;
    if (BallX !== 10'd320 || BallY !== 10'd240) begin
      errors++;
      $display("FAIL post_reset_idle X=%0d Y=%0d required 320 240", BallX, BallY);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    keycode = 8'h00;
    test_reset();
    test_left();
    test_glide();
    test_walls();
    test_vertical();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball.md
BALL -- requirements
Module: ball

Interface
REQ-001 Parameter SCREEN_X_CENTER, 320: BallX reset value.
REQ-002 Parameter SCREEN_Y_CENTER, 240: BallY reset value.
REQ-003 Parameter X_MIN, 0 / X_MAX, 639: horizontal playfield limits in pixels, inclusive.
REQ-004 Parameter Y_MIN, 0 / Y_MAX, 479: vertical playfield limits in pixels, inclusive.
REQ-005 Parameter BALL_SIZE, 4: half-width of the ball in pixels.
REQ-006 Parameter STEP, 1: pixels moved per frame along the active axis.
REQ-007 Clocking and reset SHALL use one clock; reset is synchronous and active-high.
REQ-008 frame_clk  input  1  frame-rate clock; all state SHALL update on its rising edge only.
REQ-009 Reset  input  1  synchronous active-high reset.
REQ-010 keycode  input  8  USB HID keycode; 0x1A=W up, 0x04=A left, 0x16=S down, 0x07=D right; all other values mean no key.
REQ-011 BallX  output  10  ball centre X, registered.
REQ-012 BallY  output  10  ball centre Y, registered.
REQ-013 BallS  output  10  constant BALL_SIZE.
REQ-014 last_dirX  output  4  two's-complement signed last horizontal step sign (+1=4'h1, -1=4'hF, none=4'h0), registered.
REQ-015 last_dirY  output  4  same encoding for vertical (+1 = down), registered.

Function
REQ-016 Internal signed motion registers MX and MY SHALL hold the per-frame step, each one of -STEP, 0 or +STEP.
REQ-017 Each non-reset edge, key selection SHALL be:
- W: MY=-STEP, MX=0
- S: MY=+STEP, MX=0
- A: MX=-STEP, MY=0
- D: MX=+STEP, MY=0
- any other code: MX and MY unchanged (ball keeps gliding after key release).
REQ-018 On the same edge, the position SHALL update using the newly selected motion: Xn=BallX+MX_new, Yn=BallY+MY_new; key-to-movement latency is 1 frame.
REQ-019 All position arithmetic SHALL use at least 12-bit signed intermediates; outputs SHALL be the low 10 bits; no wrap-around.
REQ-020 If Xn+BALL_SIZE > X_MAX, BallX SHALL be set to X_MAX-BALL_SIZE and MX cleared to 0; if Xn-BALL_SIZE < X_MIN, BallX SHALL be set to X_MIN+BALL_SIZE and MX cleared to 0.
REQ-021 Y SHALL be clamped identically using Y_MIN/Y_MAX, clearing MY.
REQ-022 A key pressing into a wall the ball already touches SHALL leave the position unchanged.
REQ-022a In the REQ-022 case, last_dir SHALL still be updated.
REQ-023 last_dirX/last_dirY SHALL update only when a mapped key is seen; the pressed axis takes the key's sign and the other axis becomes 0.
REQ-024 last_dirX/last_dirY SHALL not change on clamping or on unmapped keycodes.
REQ-025 A reversal (e.g. A then D) SHALL take effect on the very next edge with no intermediate stop frame.

Reset
REQ-026 When Reset=1 at a frame_clk edge, the following SHALL be set regardless of keycode:
- BallX=SCREEN_X_CENTER, BallY=SCREEN_Y_CENTER
- MX=MY=0
- last_dirX=last_dirY=4'h0
REQ-027 BallS SHALL read BALL_SIZE at all times, including during reset.
REQ-028 Reset asserted mid-motion SHALL return the ball to the centre at that edge.
REQ-029 Motion SHALL resume only from new key input after reset.

Verification
REQ-030 Reset pulse, then keycode=0x00 for 3 frames -> BallX=320, BallY=240, BallS=4, last_dirX=last_dirY=0 throughout.
REQ-031 After reset, keycode=0x04 -> 1st edge BallX=319, last_dirX=4'hF, last_dirY=0; 5th edge BallX=315; BallY=240.
REQ-032 keycode=0x07 for 1 frame then 0x00 for 2 frames -> BallX 321, 322, 323; last_dirX=4'h1 held.
REQ-033 keycode=0x04 held 400 frames -> BallX saturates at 4 and stays; last_dirX stays 4'hF.
REQ-034 keycode=0x1A for 2 frames then 0x16 -> BallY 239, 238, 239; last_dirY F, F, 1; last_dirX=0.
REQ-035 Moving right at BallX=330, Reset=1 for one edge -> BallX=320, BallY=240, dirs 0; next edge with keycode=0x00 BallX stays 320.
